// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift one byte out on
// device clocks, then check the device ACK. Outputs are open-drain pull-low enables.
`timescale 1ns/1ps

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_done,
    output logic       tx_err
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t           state, state_nx;
    logic [2:0]       clk_sync, data_sync;
    logic [9:0]       frame, frame_nx;      // {stop, parity, d7..d0}
    logic [3:0]       bit_idx, bit_idx_nx;
    logic             drive_low, drive_low_nx;
    logic [INH_W-1:0] inh_cnt, inh_cnt_nx;
    logic [TO_W-1:0]  to_cnt, to_cnt_nx;
    logic             done_nx, err_nx;
    logic             fall;
    logic             data_bit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: synchronizers reset to the idle line level (1) so no false fall follows reset.
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[1:0], ps2_data};
        end
    end

    assign fall     = clk_sync[2] & ~clk_sync[1];
    assign data_bit = data_sync[2];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            frame     <= '0;
            bit_idx   <= '0;
            drive_low <= 1'b0;
            inh_cnt   <= '0;
            to_cnt    <= '0;
            tx_done   <= 1'b0;
            tx_err    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state     <= state_nx;
            frame     <= frame_nx;
            bit_idx   <= bit_idx_nx;
            drive_low <= drive_low_nx;
            inh_cnt   <= inh_cnt_nx;
            to_cnt    <= to_cnt_nx;
            tx_done   <= done_nx;
            tx_err    <= err_nx;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        state_nx     = state;
        frame_nx     = frame;
        bit_idx_nx   = bit_idx;
        drive_low_nx = drive_low;
        inh_cnt_nx   = inh_cnt;
        to_cnt_nx    = to_cnt;
        done_nx      = 1'b0;
        err_nx       = 1'b0;

        case (state)
            S_IDLE: begin
                inh_cnt_nx   = '0;
                to_cnt_nx    = '0;
                drive_low_nx = 1'b0;
                if (tx_valid) begin
                    frame_nx = {1'b1, ~^tx_data, tx_data};
                    state_nx = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (inh_cnt == INH_LAST) begin
                    state_nx = S_REQ;
                end else begin
                    inh_cnt_nx = inh_cnt + INH_W'(1);
                end
            end

            default: begin
                // REQ, SEND, ACK and WAIT_IDLE all share the request-to-idle timeout.
                to_cnt_nx = to_cnt + TO_W'(1);
                if (to_cnt == TO_LAST) begin
                    err_nx       = 1'b1;
                    drive_low_nx = 1'b0;
                    state_nx     = S_IDLE;
                end else begin
                    case (state)
                        S_REQ: begin
                            drive_low_nx = 1'b1;
                            bit_idx_nx   = '0;
                            state_nx     = S_SEND;
                        end
                        S_SEND: begin
                            if (fall) begin
                                drive_low_nx = ~frame[bit_idx];
                                if (bit_idx == 4'd9) begin
                                    state_nx = S_ACK;
                                end else begin
                                    bit_idx_nx = bit_idx + 4'd1;
                                end
                            end
                        end
                        S_ACK: begin
                            if (fall) begin
                                if (data_bit) begin
                                    err_nx   = 1'b1;
                                    state_nx = S_IDLE;
                                end else begin
                                    state_nx = S_WAIT_IDLE;
                                end
                            end
                        end
                        S_WAIT_IDLE: begin
                            if (clk_sync[2] && data_sync[2]) begin
                                done_nx  = 1'b1;
                                state_nx = S_IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // Decoded straight from state so an async reset releases the lines immediately.
    assign tx_ready    = (state == S_IDLE);
    assign ps2_clk_oe  = (state == S_INHIBIT) || (state == S_REQ);
    assign ps2_data_oe = (state == S_REQ) || ((state == S_SEND) && drive_low);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames in and a frame/timing model
// predicts what it must receive and when the handshake pulses appear.
`timescale 1ns/1ps

module tb_ps2_host_tx;
    localparam int INH = 20;
    localparam int TO  = 2000;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_clk_line, ps2_data_line;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, tx_done, tx_err;

    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic dev_abort = 1'b0;
    int   dev_falls = 0;

    int total = 0;
    int bad = 0;
    int cyc = 0, done_cnt = 0, err_cnt = 0, runs = 0, run_len = 0;
    int req_cycle = 0, err_cycle = 0;
    logic prev_done = 1'b0, prev_err = 1'b0;

    // Open-drain lines with pull-ups.
    assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ps2_clk    (ps2_clk_line),
        .ps2_data   (ps2_data_line),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .tx_done    (tx_done),
        .tx_err     (tx_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame as the device must see it, bit 0 first: start, d0..d7, odd parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    // Cycle-level protocol rules checked on every sampled cycle.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (resetn) begin
                if (tx_done) begin
                    done_cnt++;
                    check("done_excl_err", 32'(tx_err), 32'd0);
                    check("done_in_idle", 32'(tx_ready), 32'd1);
                    check("done_one_cycle", 32'(prev_done), 32'd0);
                end
                if (tx_err) begin
                    err_cnt++;
                    err_cycle = cyc;
                    check("err_in_idle", 32'(tx_ready), 32'd1);
                    check("err_one_cycle", 32'(prev_err), 32'd0);
                end
                if (tx_ready)
                    check("idle_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
                if (ps2_clk_oe) begin
                    if (ps2_data_oe) begin
                        check("req_after_inhibit", 32'(run_len), 32'(INH));
                        req_cycle = cyc;
                    end
                    run_len++;
                end else if (run_len != 0) begin
                    check("clk_oe_width", 32'(run_len), 32'(INH + 1));
                    runs++;
                    run_len = 0;
                end
                prev_done = tx_done;
                prev_err  = tx_err;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(tx_ready), 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
        check("busy_after_accept", 32'(tx_ready), 32'd0);
    endtask

    // Device: waits out the inhibit, then 11 clocks; samples data before each fall.
    task automatic device_rx(input bit ack, output logic [10:0] fr);
        int n = 0;
        fr = '0;
        dev_falls = 0;
        while (!ps2_clk_oe && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("dev_saw_inhibit", 32'(ps2_clk_oe), 32'd1);
        n = 0;
        while (ps2_clk_oe && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("dev_saw_release", 32'(ps2_clk_oe), 32'd0);
        repeat (30) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            if (dev_abort) break;
            fr[i] = ps2_data_line;
            if (i == 10 && ack) begin
                dev_data_low = 1'b1;
                repeat (5) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            dev_falls++;
            repeat (40) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (40) @(negedge clk);
        end
        dev_data_low = 1'b0;
        dev_clk_low  = 1'b0;
    endtask

    task automatic settle();
        int n = 0;
        while (!tx_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] fr;
        logic [10:0] fr3 [3];
        int d0, e0, r0, n;

        // Reset state
        #1;
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check("rst_pulses", 32'({tx_done, tx_err}), 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // 0xED with ACK
        d0 = done_cnt; e0 = err_cnt; r0 = runs;
        fork
            send_byte(8'hED);
            device_rx(1'b1, fr);
        join
        settle();
        check("ed_frame_literal", 32'(fr), 32'h7DA);
        check("ed_frame_model", 32'(fr), 32'(model_frame(8'hED)));
        check("ed_done", 32'(done_cnt - d0), 32'd1);
        check("ed_no_err", 32'(err_cnt - e0), 32'd0);
        check("ed_one_inhibit", 32'(runs - r0), 32'd1);

        // Back-to-back 0x01, 0xFF, 0x00 with tx_valid held
        d0 = done_cnt;
        fork
            begin
                @(negedge clk);
                tx_data  = 8'h01;
                tx_valid = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    n = 0;
                    while (!tx_ready && n < 3000) begin
                        @(negedge clk);
                        n++;
                    end
                    check("b2b_ready", 32'(tx_ready), 32'd1);
                    if (k > 0) check("b2b_first_idle", 32'(tx_done), 32'd1);
                    @(negedge clk);
                    check("b2b_taken", 32'(tx_ready), 32'd0);
                    if (k == 0) tx_data = 8'hFF;
                    else if (k == 1) tx_data = 8'h00;
                    else tx_valid = 1'b0;
                end
            end
            begin
                for (int k = 0; k < 3; k++) device_rx(1'b1, fr3[k]);
            end
        join
        settle();
        check("b2b_par_01", 32'(fr3[0][9]), 32'd0);
        check("b2b_par_ff", 32'(fr3[1][9]), 32'd1);
        check("b2b_par_00", 32'(fr3[2][9]), 32'd1);
        check("b2b_frame_01", 32'(fr3[0]), 32'(model_frame(8'h01)));
        check("b2b_frame_ff", 32'(fr3[1]), 32'(model_frame(8'hFF)));
        check("b2b_frame_00", 32'(fr3[2]), 32'(model_frame(8'h00)));
        check("b2b_done", 32'(done_cnt - d0), 32'd3);

        // NACK: device leaves data high on the 11th fall
        d0 = done_cnt; e0 = err_cnt;
        fork
            send_byte(8'hA5);
            device_rx(1'b0, fr);
        join
        settle();
        check("nack_frame", 32'(fr), 32'(model_frame(8'hA5)));
        check("nack_err", 32'(err_cnt - e0), 32'd1);
        check("nack_no_done", 32'(done_cnt - d0), 32'd0);
        check("nack_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check("nack_ready", 32'(tx_ready), 32'd1);

        // Timeout: device never clocks
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'h3C);
        n = 0;
        while (err_cnt == e0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("to_err", 32'(err_cnt - e0), 32'd1);
        check("to_latency", 32'(err_cycle - req_cycle), 32'(TO));
        check("to_no_done", 32'(done_cnt - d0), 32'd0);
        @(negedge clk);
        check("to_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check("to_ready", 32'(tx_ready), 32'd1);

        // Async reset while bit 4 (a 0) of 0x0F is on the line
        fork
            send_byte(8'h0F);
            device_rx(1'b1, fr);
            begin
                n = 0;
                while (dev_falls < 5 && n < 5000) begin
                    @(negedge clk);
                    n++;
                end
                repeat (10) @(negedge clk);
                check("pre_reset_bit4", 32'(ps2_data_oe), 32'd1);
                #2 resetn = 1'b0;
                #1;
                check("async_rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
                check("async_rst_ready", 32'(tx_ready), 32'd1);
                dev_abort = 1'b1;
                repeat (3) @(negedge clk);
                resetn = 1'b1;
            end
        join
        dev_abort = 1'b0;
        repeat (5) @(negedge clk);
        d0 = done_cnt;
        fork
            send_byte(8'h55);
            device_rx(1'b1, fr);
        join
        settle();
        check("post_rst_frame", 32'(fr), 32'(model_frame(8'h55)));
        check("post_rst_done", 32'(done_cnt - d0), 32'd1);

        // tx_valid pulse with 0xAA during SEND of 0x12 is ignored
        d0 = done_cnt; r0 = runs;
        fork
            send_byte(8'h12);
            device_rx(1'b1, fr);
            begin
                n = 0;
                while (dev_falls < 3 && n < 5000) begin
                    @(negedge clk);
                    n++;
                end
                @(negedge clk);
                tx_data  = 8'hAA;
                tx_valid = 1'b1;
                check("busy_ready_low", 32'(tx_ready), 32'd0);
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        settle();
        repeat (100) @(negedge clk);
        check("ign_frame", 32'(fr), 32'(model_frame(8'h12)));
        check("ign_done", 32'(done_cnt - d0), 32'd1);
        check("ign_one_inhibit", 32'(runs - r0), 32'd1);
        check("ign_ready", 32'(tx_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
